pixel_write_queue: RTL

//  Buffers pixel writes from the MCU interface and delivers them one at a time to the

---
 rtl/pixel_write_queue.sv | 131 +++++++++++++
 1 files changed

// File: rtl/pixel_write_queue.sv
// Pixel write queue: buffers MCU pixel writes in a circular FIFO and issues them
// one at a time to the memory manager over a request/complete handshake.
module pixel_write_queue #(
    parameter int DEPTH     = 8,
    parameter int PTR_WIDTH = 3
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 pixelWriteValid_i,
    input  logic [8:0]           pixelX_i,
    input  logic [7:0]           pixelY_i,
    input  logic [7:0]           pixelColor_i,
    input  logic                 overflowClear_i,
    output logic [8:0]           memoryXCoord_o,
    output logic [7:0]           memoryYCoord_o,
    output logic [7:0]           memoryWriteData_o,
    output logic                 memoryWriteRequest_o,
    input  logic                 memoryWriteComplete_i,
    output logic [PTR_WIDTH:0]   queueCount_o,
    output logic                 queueFull_o,
    output logic                 queueEmpty_o,
    output logic                 overflow_o,
    output logic                 busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQUEST,
        ST_GAP
    } state_t;

    localparam logic [PTR_WIDTH:0] DEPTH_C = (PTR_WIDTH + 1)'(DEPTH);

    state_t               state_q;
    logic [24:0]          entry_q [DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr_q;
    logic [PTR_WIDTH-1:0] rd_ptr_q;
    logic [PTR_WIDTH:0]   count_q;
    logic [PTR_WIDTH:0]   count_d;
    logic                 full_q;
    logic                 empty_q;
    logic                 overflow_q;
    logic                 req_q;
    logic [8:0]           x_q;
    logic [7:0]           y_q;
    logic [7:0]           data_q;
    logic                 pop;
    logic                 push;

    // A full queue still accepts a push when the head is leaving in the same cycle.
    assign pop  = (state_q == ST_IDLE) && (count_q != '0);
    assign push = pixelWriteValid_i && ((count_q < DEPTH_C) || pop);

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clock_i) begin
        if (push) begin
            entry_q[wr_ptr_q] <= {pixelX_i, pixelY_i, pixelColor_i};
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            req_q      <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            data_q     <= '0;
        end else begin
            count_q <= count_d;
            full_q  <= (count_d == DEPTH_C);
            empty_q <= (count_d == '0);
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pixelWriteValid_i && !push) begin
                overflow_q <= 1'b1;
            end else if (overflowClear_i) begin
                overflow_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        {x_q, y_q, data_q} <= entry_q[rd_ptr_q];
                        rd_ptr_q           <= rd_ptr_q + 1'b1;
                        req_q              <= 1'b1;
                        state_q            <= ST_REQUEST;
                    end
                end
                ST_REQUEST: begin
                    if (memoryWriteComplete_i) begin
                        req_q   <= 1'b0;
                        state_q <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    req_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign memoryXCoord_o       = x_q;
    assign memoryYCoord_o       = y_q;
    assign memoryWriteData_o    = data_q;
    assign memoryWriteRequest_o = req_q;
    assign queueCount_o         = count_q;
    assign queueFull_o          = full_q;
    assign queueEmpty_o         = empty_q;
    assign overflow_o           = overflow_q;
    assign busy_o               = !empty_q || (state_q != ST_IDLE);

endmodule
